// File: rtl/ch3_wave_sequencer.sv
// ch3_wave_sequencer
//  Sequencer and arbiter for the channel-3 wave RAM (16 x 8-bit).
//  Runs the ch3 frequency timer (stepped at 2 MHz by an internal prescaler)
//  and the sample position counter. Each position advance triggers one
//  playback fetch. The RAM port is shared with CPU accesses, and playback
//  fetches have priority over the CPU.
//
//  Optional feature macro: CH3_CPU_ACCESS_QUIRK_EN
//   When it is defined and the channel is active, CPU accesses are forced to
//   the current playback byte. They are honoured only in the wave_latch cycle.
//   Any other CPU access is acknowledged with cpu_blocked=1 and no RAM strobe.
//
// Ports
//  amuk_4mhz    in   APU clock; all state changes on the rising edge
//  apu_reset    in   asynchronous active-high reset
//  ch3_freq     in   period (NR33/NR34), loaded on trigger and on overflow
//  ch3_trigger  in   1-cycle trigger pulse
//  ch3_dac_en   in   DAC enable; low forces the channel off
//  ch3_stop     in   1-cycle length-expiry pulse
//  cpu_req      in   CPU access request, held until cpu_ack
//  cpu_we       in   1 = write, 0 = read
//  cpu_addr     in   CPU byte address
//  cpu_ack      out  CPU access performed (or suppressed) this cycle
//  cpu_blocked  out  access was suppressed (quirk only, else 0)
//  wave_addr    out  RAM byte address
//  wave_ram_rd  out  RAM read enable
//  wave_ram_wr  out  RAM write enable
//  wave_latch   out  strobe in the cycle after a playback fetch
//  nibble_sel   out  0 = high nibble, 1 = low nibble
//  ch3_active   out  channel running
module ch3_wave_sequencer #(
  parameter int unsigned FREQ_W = 11,
  parameter int unsigned POS_W  = 5
) (
  input  logic              amuk_4mhz,
  input  logic              apu_reset,
  input  logic [FREQ_W-1:0] ch3_freq,
  input  logic              ch3_trigger,
  input  logic              ch3_dac_en,
  input  logic              ch3_stop,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [POS_W-2:0]  cpu_addr,
  output logic              cpu_ack,
  output logic              cpu_blocked,
  output logic [POS_W-2:0]  wave_addr,
  output logic              wave_ram_rd,
  output logic              wave_ram_wr,
  output logic              wave_latch,
  output logic              nibble_sel,
  output logic              ch3_active
);

  typedef enum logic [1:0] {StIdle, StRun, StFetch} state_e;

  state_e            state_q, state_d;
  logic [FREQ_W-1:0] timer_q, timer_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              presc_q;
  logic              active_q, active_d;
  logic              latch_q, latch_d;

  logic kill;
  logic fetch_cycle;
  logic cpu_go;

  assign kill        = ~ch3_dac_en | ch3_stop;
  assign fetch_cycle = (state_q == StFetch);
  // The CPU is masked while reset is asserted, so a pending request is never acknowledged.
  assign cpu_go      = cpu_req & ~apu_reset & ~fetch_cycle;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    pos_d    = pos_q;
    active_d = active_q;
    latch_d  = 1'b0;
    if (kill) begin
      // Stop beats trigger. Position and timer keep their values.
      state_d  = StIdle;
      active_d = 1'b0;
    end else if (ch3_trigger) begin
      // A restart beats a timer overflow and aborts any in-flight fetch.
      state_d  = StRun;
      timer_d  = ch3_freq;
      pos_d    = '0;
      active_d = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (presc_q) begin
            if (timer_q == '1) begin
              timer_d = ch3_freq;
              pos_d   = pos_q + 1'b1;
              state_d = StFetch;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
        end
        StFetch: begin
          state_d = StRun;
          latch_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge amuk_4mhz or posedge apu_reset) begin
    if (apu_reset) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      pos_q    <= '0;
      presc_q  <= 1'b0;
      active_q <= 1'b0;
      latch_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      pos_q    <= pos_d;
      presc_q  <= ~presc_q;
      active_q <= active_d;
      latch_q  <= latch_d;
    end
  end

  // RAM port arbitration. A playback fetch owns the port, and a CPU request
  // that collides with it is still held on the next cycle, when it is served.
  always_comb begin
    wave_addr   = '0;
    wave_ram_rd = 1'b0;
    wave_ram_wr = 1'b0;
    cpu_ack     = 1'b0;
    cpu_blocked = 1'b0;
    if (fetch_cycle) begin
      wave_ram_rd = 1'b1;
      wave_addr   = pos_q[POS_W-1:1];
    end else if (cpu_go) begin
      cpu_ack = 1'b1;
`ifdef CH3_CPU_ACCESS_QUIRK_EN
      if (active_q && !latch_q) begin
        cpu_blocked = 1'b1;
      end else begin
        wave_ram_rd = ~cpu_we;
        wave_ram_wr = cpu_we;
        wave_addr   = active_q ? pos_q[POS_W-1:1] : cpu_addr;
      end
`else
      wave_ram_rd = ~cpu_we;
      wave_ram_wr = cpu_we;
      wave_addr   = cpu_addr;
`endif
    end
  end

  assign wave_latch = latch_q;
  assign nibble_sel = pos_q[0];
  assign ch3_active = active_q;

endmodule

// File: tb/tb_ch3_wave_sequencer.sv
module tb_ch3_wave_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] ch3_freq = '0;
  logic        ch3_trigger = 1'b0;
  logic        ch3_dac_en = 1'b1;
  logic        ch3_stop = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [3:0]  cpu_addr = '0;
  logic        cpu_ack, cpu_blocked, wave_ram_rd, wave_ram_wr, wave_latch;
  logic        nibble_sel, ch3_active;
  logic [3:0]  wave_addr;

  ch3_wave_sequencer dut (
    .amuk_4mhz  (clk),
    .apu_reset  (rst),
    .ch3_freq   (ch3_freq),
    .ch3_trigger(ch3_trigger),
    .ch3_dac_en (ch3_dac_en),
    .ch3_stop   (ch3_stop),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_ack    (cpu_ack),
    .cpu_blocked(cpu_blocked),
    .wave_addr  (wave_addr),
    .wave_ram_rd(wave_ram_rd),
    .wave_ram_wr(wave_ram_wr),
    .wave_latch (wave_latch),
    .nibble_sel (nibble_sel),
    .ch3_active (ch3_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rd;
    logic       wr;
    logic       ack;
    logic       blk;
    logic [3:0] addr;
    logic       chk_nib;
    logic       nib;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  rd_cnt = 0;
  int  latch_cnt = 0;
  int  last_rd = -1;
  int  exp_gap = 0;
  logic prev_fetch = 1'b0;

  // Scoreboard monitor: every RAM strobe or ack must match the next expected event.
  always @(negedge clk) begin
    ev_t e;
    logic playback;
    cyc = cyc + 1;
    if (wave_ram_rd && wave_ram_wr) begin
      checks++;
      errors++;
      $display("FAIL rd_wr_exclusive cyc=%0d got rd=1 wr=1 required not both", cyc);
    end
    if (wave_ram_rd || wave_ram_wr || cpu_ack) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_access cyc=%0d got rd=%0b wr=%0b ack=%0b blk=%0b addr=%0d required none",
                 cyc, wave_ram_rd, wave_ram_wr, cpu_ack, cpu_blocked, wave_addr);
      end else begin
        e = exp_q.pop_front();
        if ({wave_ram_rd, wave_ram_wr, cpu_ack, cpu_blocked, wave_addr} !==
            {e.rd, e.wr, e.ack, e.blk, e.addr} || (e.chk_nib && nibble_sel !== e.nib)) begin
          errors++;
          $display("FAIL access cyc=%0d got rd=%0b wr=%0b ack=%0b blk=%0b addr=%0d nib=%0b required rd=%0b wr=%0b ack=%0b blk=%0b addr=%0d nib=%0b",
                   cyc, wave_ram_rd, wave_ram_wr, cpu_ack, cpu_blocked, wave_addr, nibble_sel,
                   e.rd, e.wr, e.ack, e.blk, e.addr, e.nib);
        end
      end
    end
    if (wave_latch) begin
      checks++;
      latch_cnt++;
      if (!prev_fetch) begin
        errors++;
        $display("FAIL latch_after_fetch cyc=%0d got latch without preceding fetch", cyc);
      end
    end
    playback = wave_ram_rd && !cpu_ack;
    if (playback) begin
      rd_cnt++;
      if (exp_gap != 0 && last_rd >= 0) begin
        checks++;
        if (cyc - last_rd != exp_gap) begin
          errors++;
          $display("FAIL fetch_gap cyc=%0d got %0d required %0d", cyc, cyc - last_rd, exp_gap);
        end
      end
      last_rd = cyc;
    end
    prev_fetch = playback;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input int pos);
    ev_t e;
    logic [4:0] p;
    p = pos[4:0];
    e.rd = 1'b1; e.wr = 1'b0; e.ack = 1'b0; e.blk = 1'b0;
    e.addr = p[4:1]; e.chk_nib = 1'b1; e.nib = p[0];
    exp_q.push_back(e);
  endtask

  task automatic push_cpu(input logic rd, input logic wr, input logic blk, input logic [3:0] addr);
    ev_t e;
    e.rd = rd; e.wr = wr; e.ack = 1'b1; e.blk = blk;
    e.addr = addr; e.chk_nib = 1'b0; e.nib = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic trigger(input logic [10:0] f);
    ch3_freq = f;
    ch3_trigger = 1'b1;
    tick();
    ch3_trigger = 1'b0;
  endtask

  task automatic wait_rd(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (rd_cnt < target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (rd_cnt < target) begin
      errors++;
      $display("FAIL %s_timeout got %0d fetches required %0d", name, rd_cnt, target);
    end
  endtask

  task automatic stop_now();
    ch3_stop = 1'b1;
    tick();
    ch3_stop = 1'b0;
  endtask

  task automatic check_drained(input string name);
    repeat (8) tick();
    checks++;
    if (exp_q.size() != 0 || ch3_active !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain got pending=%0d active=%0b required 0 0", name, exp_q.size(), ch3_active);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    cpu_req = 1'b1;
    tick();
    tick();
    checks++;
    if ({cpu_ack, cpu_blocked, wave_addr, wave_ram_rd, wave_ram_wr, wave_latch,
         nibble_sel, ch3_active} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs got ack=%0b rd=%0b addr=%0d active=%0b required all 0",
               cpu_ack, wave_ram_rd, wave_addr, ch3_active);
    end
    cpu_req = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch_rate();
    int base, lbase;
    base = rd_cnt;
    lbase = latch_cnt;
    exp_gap = 2;
    last_rd = -1;
    for (int i = 1; i <= 6; i++) push_fetch(i);
    trigger(11'd2047);
    checks++;
    if (ch3_active !== 1'b1) begin
      errors++;
      $display("FAIL trigger_active got %0b required 1", ch3_active);
    end
    wait_rd(base + 6, 40, "fetch_rate");
    stop_now();
    check_drained("fetch_rate");
    checks++;
    if (latch_cnt - lbase != 6) begin
      errors++;
      $display("FAIL fetch_rate_latches got %0d required 6", latch_cnt - lbase);
    end
    exp_gap = 0;
  endtask

  task automatic test_wrap();
    int base;
    base = rd_cnt;
    exp_gap = 4;
    last_rd = -1;
    for (int i = 1; i <= 33; i++) push_fetch(i);
    trigger(11'd2046);
    wait_rd(base + 33, 200, "wrap");
    stop_now();
    check_drained("wrap");
    exp_gap = 0;
  endtask

  task automatic test_retrigger();
    int base;
    base = rd_cnt;
    push_fetch(1);
    push_fetch(2);
    push_fetch(1);
    trigger(11'd2047);
    wait_rd(base + 1, 20, "retrigger");
    tick();
    ch3_trigger = 1'b1;
    tick();
    ch3_trigger = 1'b0;
    checks++;
    if (wave_latch !== 1'b0 || nibble_sel !== 1'b0) begin
      errors++;
      $display("FAIL retrigger_abort got latch=%0b nib=%0b required 0 0", wave_latch, nibble_sel);
    end
    wait_rd(base + 3, 20, "retrigger");
    stop_now();
    check_drained("retrigger");
  endtask

  task automatic test_collision();
    int base;
    base = rd_cnt;
    push_fetch(1);
    push_fetch(2);
`ifdef CH3_CPU_ACCESS_QUIRK_EN
    push_cpu(1'b0, 1'b1, 1'b0, 4'd1);
`else
    push_cpu(1'b0, 1'b1, 1'b0, 4'd5);
`endif
    push_fetch(3);
    trigger(11'd2047);
    wait_rd(base + 1, 20, "collision");
    tick();
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 4'd5;
    #1;
    checks++;
    if (wave_ram_rd !== 1'b1 || wave_ram_wr !== 1'b0 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL collision_fetch_first got rd=%0b wr=%0b ack=%0b required 1 0 0",
               wave_ram_rd, wave_ram_wr, cpu_ack);
    end
    tick();
    checks++;
    if (cpu_ack !== 1'b1 || wave_ram_wr !== 1'b1) begin
      errors++;
      $display("FAIL collision_cpu_next got ack=%0b wr=%0b required 1 1", cpu_ack, wave_ram_wr);
    end
    tick();
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    ch3_stop = 1'b1;
    tick();
    ch3_stop = 1'b0;
    checks++;
    if (wave_latch !== 1'b0) begin
      errors++;
      $display("FAIL stop_in_fetch_latch got %0b required 0", wave_latch);
    end
    check_drained("collision");
  endtask

  task automatic test_dac_off();
    int base;
    base = rd_cnt;
    push_fetch(1);
    trigger(11'd2046);
    wait_rd(base + 1, 20, "dac_off");
    ch3_dac_en = 1'b0;
    tick();
    checks++;
    if (ch3_active !== 1'b0) begin
      errors++;
      $display("FAIL dac_off_active got %0b required 0", ch3_active);
    end
    repeat (20) tick();
    checks++;
    if (rd_cnt != base + 1) begin
      errors++;
      $display("FAIL dac_off_fetches got %0d required %0d", rd_cnt - base, 1);
    end
    trigger(11'd2047);
    checks++;
    if (ch3_active !== 1'b0) begin
      errors++;
      $display("FAIL trigger_dac_off got active=%0b required 0", ch3_active);
    end
    ch3_dac_en = 1'b1;
    ch3_stop = 1'b1;
    trigger(11'd2047);
    ch3_stop = 1'b0;
    checks++;
    if (ch3_active !== 1'b0) begin
      errors++;
      $display("FAIL trigger_stop_same got active=%0b required 0", ch3_active);
    end
    push_cpu(1'b1, 1'b0, 1'b0, 4'd9);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 4'd9;
    #1;
    checks++;
    if (cpu_ack !== 1'b1 || wave_ram_rd !== 1'b1 || wave_addr !== 4'd9) begin
      errors++;
      $display("FAIL idle_cpu_read got ack=%0b rd=%0b addr=%0d required 1 1 9",
               cpu_ack, wave_ram_rd, wave_addr);
    end
    tick();
    cpu_req = 1'b0;
    check_drained("dac_off");
  endtask

  task automatic test_reset_in_fetch();
    int base, lbase;
    base = rd_cnt;
    push_fetch(1);
    trigger(11'd2047);
    wait_rd(base + 1, 20, "reset_fetch");
    tick();
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 4'd3;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({cpu_ack, wave_ram_rd, wave_ram_wr, wave_addr, wave_latch, ch3_active,
         nibble_sel} !== 10'b0) begin
      errors++;
      $display("FAIL reset_in_fetch got ack=%0b rd=%0b addr=%0d active=%0b required all 0",
               cpu_ack, wave_ram_rd, wave_addr, ch3_active);
    end
    lbase = latch_cnt;
    tick();
    checks++;
    if (wave_latch !== 1'b0 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_latch got latch=%0b ack=%0b required 0 0", wave_latch, cpu_ack);
    end
    cpu_req = 1'b0;
    rst = 1'b0;
    check_drained("reset_fetch");
    checks++;
    if (latch_cnt != lbase) begin
      errors++;
      $display("FAIL reset_latch_count got %0d required %0d", latch_cnt, lbase);
    end
  endtask

`ifdef CH3_CPU_ACCESS_QUIRK_EN
  task automatic test_quirk();
    int base;
    base = rd_cnt;
    push_fetch(1);
    push_cpu(1'b0, 1'b0, 1'b1, 4'd0);
    push_fetch(2);
    push_cpu(1'b1, 1'b0, 1'b0, 4'd1);
    trigger(11'd2046);
    wait_rd(base + 1, 20, "quirk");
    tick();
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 4'd9;
    #1;
    checks++;
    if (cpu_ack !== 1'b1 || cpu_blocked !== 1'b1 || wave_ram_rd !== 1'b0) begin
      errors++;
      $display("FAIL quirk_blocked got ack=%0b blk=%0b rd=%0b required 1 1 0",
               cpu_ack, cpu_blocked, wave_ram_rd);
    end
    tick();
    cpu_req = 1'b0;
    wait_rd(base + 2, 20, "quirk");
    cpu_req = 1'b1;
    #1;
    checks++;
    if (cpu_ack !== 1'b1 || cpu_blocked !== 1'b0 || wave_ram_rd !== 1'b1 || wave_addr !== 4'd1) begin
      errors++;
      $display("FAIL quirk_window got ack=%0b blk=%0b rd=%0b addr=%0d required 1 0 1 1",
               cpu_ack, cpu_blocked, wave_ram_rd, wave_addr);
    end
    tick();
    cpu_req = 1'b0;
    stop_now();
    check_drained("quirk");
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_rate();
    test_wrap();
    test_retrigger();
    test_collision();
    test_dac_off();
    test_reset_in_fetch();
`ifdef CH3_CPU_ACCESS_QUIRK_EN
    test_quirk();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
